// File: rtl/neo_frame_ctrl.sv
// APB3-programmed frame sequencer for a NeoPixel LED chain: shadow pixel RAM, SEND/LATCH FSM.
// Optional periodic re-send of the frame is enabled by defining NEO_AUTO_REFRESH_EN.
module neo_frame_ctrl #(
    parameter int NUM_PIX        = 30,
    parameter int LATCH_CYCLES   = 900000,
    parameter int REFRESH_CYCLES = 5000000
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [4:0]  pix_index,
    output logic [23:0] pix_data,
    output logic        pix_last,
    output logic        pix_latch,
    output logic        busy,
    output logic        irq_done
);
    localparam int          LCW       = $clog2(LATCH_CYCLES + 1);
    localparam logic [11:0] ADDR_PIX  = 12'h010;
    localparam logic [11:0] ADDR_CTRL = 12'h014;
    localparam logic [4:0]  LAST_IDX  = 5'(NUM_PIX - 1);
    localparam logic [5:0]  NPIX6     = 6'(NUM_PIX);
    localparam logic [LCW-1:0] LATCH_END = LCW'(LATCH_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

    state_t           state_q, state_d;
    logic [4:0]       k_q, k_d;
    logic [LCW-1:0]   lcnt_q, lcnt_d;
    logic             pend_q, pend_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             irq_q, irq_d;
    logic [23:0]      shadow_q [NUM_PIX];
    logic             start;
    logic             refresh;

    logic apb_wr, pix_wr, ctrl_wr, commit_wr, pix_idx_ok;
    assign apb_wr     = PSEL && PENABLE && PWRITE;
    assign pix_wr     = apb_wr && (PADDR[11:0] == ADDR_PIX);
    assign ctrl_wr    = apb_wr && (PADDR[11:0] == ADDR_CTRL);
    assign commit_wr  = ctrl_wr && PWDATA[0];
    assign pix_idx_ok = {1'b0, PWDATA[28:24]} < NPIX6;

    logic unused_ok;
    assign unused_ok = ^{PADDR[31:12], PWDATA[31:29]};

`ifdef NEO_AUTO_REFRESH_EN
    localparam int RCW = $clog2(REFRESH_CYCLES + 1);
    localparam logic [RCW-1:0] REFRESH_END = RCW'(REFRESH_CYCLES - 1);
    logic [RCW-1:0] rtmr_q, rtmr_d;

    // Timer only runs while idle and restarts from zero whenever a frame begins.
    assign refresh = (state_q == IDLE) && (rtmr_q == REFRESH_END);
    assign rtmr_d  = ((state_q == IDLE) && !start) ? rtmr_q + 1'b1 : '0;

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) rtmr_q <= '0;
        else          rtmr_q <= rtmr_d;
    end
`else
    logic unused_refresh;
    assign refresh        = 1'b0;
    assign unused_refresh = (REFRESH_CYCLES != 0);
`endif

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        lcnt_d  = lcnt_q;
        pend_d  = pend_q;
        done_d  = done_q;
        err_d   = err_q;
        irq_d   = 1'b0;
        start   = 1'b0;
        if (ctrl_wr && PWDATA[1]) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end
        if (pix_wr && !pix_idx_ok) err_d = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (commit_wr || pend_q || refresh) begin
                    start   = 1'b1;
                    state_d = SEND;
                    k_d     = '0;
                    pend_d  = 1'b0;
                end
            end
            SEND: begin
                if (commit_wr) pend_d = 1'b1;
                if (pix_ready) begin
                    if (k_q == LAST_IDX) begin
                        state_d = LATCH;
                        k_d     = '0;
                        lcnt_d  = '0;
                    end else begin
                        k_d = k_q + 5'd1;
                    end
                end
            end
            LATCH: begin
                if (commit_wr) pend_d = 1'b1;
                if (lcnt_q == LATCH_END) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    irq_d   = 1'b1;
                end else begin
                    lcnt_d = lcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state_q <= IDLE;
            k_q     <= '0;
            lcnt_q  <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            lcnt_q  <= lcnt_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            err_q   <= err_d;
            irq_q   <= irq_d;
        end
    end

    // Shadow RAM: the driver reads the pre-edge value, so a same-cycle write is seen next cycle.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            for (int i = 0; i < NUM_PIX; i++) shadow_q[i] <= '0;
        end else if (pix_wr && pix_idx_ok) begin
            shadow_q[PWDATA[28:24]] <= PWDATA[23:0];
        end
    end

    assign busy      = (state_q != IDLE);
    assign pix_valid = (state_q == SEND);
    assign pix_index = pix_valid ? k_q : '0;
    assign pix_data  = pix_valid ? shadow_q[k_q] : '0;
    assign pix_last  = pix_valid && (k_q == LAST_IDX);
    assign pix_latch = (state_q == LATCH);
    assign irq_done  = irq_q;
    assign PREADY    = 1'b1;
    assign PSLVERR   = 1'b0;

    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE && (PADDR[11:0] == ADDR_CTRL))
            PRDATA = {28'b0, err_q, done_q, pend_q, busy};
    end
endmodule

// File: tb/tb_neo_frame_ctrl.sv
// Bench for neo_frame_ctrl: random pixel data and ready patterns checked against a
// shadow-memory model; every sampled cycle is logged and frames are reconstructed from it.
`timescale 1ns/1ps
module tb_neo_frame_ctrl;
    localparam int NP = 30;
    localparam int LC = 50;
    localparam int RC = 1000;
    localparam logic [31:0] A_PIX  = 32'h010;
    localparam logic [31:0] A_CTRL = 32'h014;

    logic        PCLK = 1'b0, PRESERN = 1'b1;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [31:0] PADDR = '0, PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR, pix_valid, pix_last, pix_latch, busy, irq_done;
    logic        pix_ready = 1'b0;
    logic [4:0]  pix_index;
    logic [23:0] pix_data;

    int checks = 0, errors = 0, cyc = 0;
    logic [23:0] model [NP];
    logic m_err = 1'b0, m_done = 1'b0;

    typedef struct { int c; logic v, r, l, lat, irq; logic [4:0] idx; logic [23:0] dat; } smp_t;
    smp_t log_q[$];
    logic [29:0] hs_q[$];

    neo_frame_ctrl #(.NUM_PIX(NP), .LATCH_CYCLES(LC), .REFRESH_CYCLES(RC)) dut (
        .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_index(pix_index), .pix_data(pix_data),
        .pix_last(pix_last), .pix_latch(pix_latch), .busy(busy), .irq_done(irq_done));

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    always @(negedge PCLK) begin
        smp_t s;
        s.c = cyc; s.v = pix_valid; s.r = pix_ready; s.l = pix_last; s.lat = pix_latch;
        s.irq = irq_done; s.idx = pix_index; s.dat = pix_data;
        log_q.push_back(s);
    end

    task automatic tick();
        @(posedge PCLK); #1;
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
        tick();
        PENABLE = 1'b1;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
        tick();
        PENABLE = 1'b1;
        @(negedge PCLK);
        d = PRDATA;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic pix_write(input int idx, input logic [23:0] d);
        apb_write(A_PIX, {3'b0, 5'(idx), d});
        if (idx < NP) model[idx] = d;
        else m_err = 1'b1;
    endtask

    task automatic clear_status();
        apb_write(A_CTRL, 32'h2);
        m_done = 1'b0; m_err = 1'b0;
    endtask

    task automatic randomize_model();
        for (int i = 0; i < NP; i++) pix_write(i, 24'($urandom));
    endtask

    // mode 0: ready always high, 1: one cycle on then two off, 2: random
    task automatic run_frame(input int mode, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            case (mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = (i % 3 == 0);
                default: pix_ready = 1'($urandom_range(0, 1));
            endcase
            tick();
            if (irq_done) ok = 1'b1;
        end
        pix_ready = 1'b0;
    endtask

    task automatic collect_hs();
        hs_q.delete();
        foreach (log_q[j]) if (log_q[j].v && log_q[j].r) hs_q.push_back({log_q[j].l, log_q[j].idx, log_q[j].dat});
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        #2 PRESERN = 1'b0;
        repeat (3) tick();
        @(negedge PCLK);
        checks++;
        if ({pix_valid, pix_last, pix_latch, busy, irq_done} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 00000", {pix_valid, pix_last, pix_latch, busy, irq_done});
        end
        checks++;
        if (pix_index !== 5'd0 || pix_data !== 24'd0 || PRDATA !== 32'd0) begin
            errors++; $display("FAIL reset_data: got idx=%0d data=%h prdata=%h expected zeros", pix_index, pix_data, PRDATA);
        end
        checks++;
        if (PREADY !== 1'b1 || PSLVERR !== 1'b0) begin
            errors++; $display("FAIL apb_tieoffs: got pready=%b pslverr=%b expected 1/0", PREADY, PSLVERR);
        end
        tick();
        PRESERN = 1'b1;
        tick();
        for (int i = 0; i < NP; i++) model[i] = '0;
        m_err = 1'b0; m_done = 1'b0;
        apb_read(A_CTRL, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL reset_status: got %h expected 0", rd); end
    endtask

    task automatic test_basic_frame();
        bit ok; logic [31:0] rd; int nlat = 0, nirq = 0, lastpos = -1;
        pix_write(0, 24'hFF0000);
        pix_write(1, 24'h00FF00);
        log_q.delete();
        apb_write(A_CTRL, 32'h1);
        checks++;
        if (pix_valid !== 1'b1 || pix_index !== 5'd0) begin
            errors++; $display("FAIL basic_start: got valid=%b idx=%0d expected 1/0", pix_valid, pix_index);
        end
        run_frame(0, 200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_done: got no irq_done expected one within 200 cycles"); end
        tick();
        collect_hs();
        checks++;
        if (hs_q.size() != NP) begin errors++; $display("FAIL basic_count: got %0d expected %0d", hs_q.size(), NP); end
        foreach (hs_q[i]) if (i < NP) begin
            checks++;
            if (hs_q[i] !== {i == NP - 1, 5'(i), model[i]}) begin
                errors++; $display("FAIL basic_pix%0d: got %h expected %h", i, hs_q[i], {i == NP - 1, 5'(i), model[i]});
            end
        end
        foreach (log_q[j]) begin
            nlat += int'(log_q[j].lat);
            nirq += int'(log_q[j].irq);
            if (log_q[j].v && log_q[j].r && log_q[j].l) lastpos = j;
        end
        checks++;
        if (nlat != LC || nirq != 1) begin
            errors++; $display("FAIL basic_latch: got latch=%0d irq=%0d expected %0d/1", nlat, nirq, LC);
        end
        checks++;
        if (lastpos < 0 || log_q[lastpos + 1].lat !== 1'b1 || log_q[lastpos + 1].v !== 1'b0) begin
            errors++; $display("FAIL basic_latch_entry: got pos=%0d expected latch right after last pixel", lastpos);
        end
        m_done = 1'b1;
        apb_read(A_CTRL, rd);
        checks++;
        if (rd !== {28'b0, m_err, m_done, 2'b00}) begin
            errors++; $display("FAIL basic_status: got %h expected %h", rd, {28'b0, m_err, m_done, 2'b00});
        end
    endtask

    task automatic test_stall();
        bit ok; int bad = 0, stalls = 0;
        clear_status();
        randomize_model();
        log_q.delete();
        apb_write(A_CTRL, 32'h1);
        run_frame(1, 400, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_done: got no irq_done expected one within 400 cycles"); end
        m_done = 1'b1;
        collect_hs();
        checks++;
        if (hs_q.size() != NP) begin errors++; $display("FAIL stall_count: got %0d expected %0d", hs_q.size(), NP); end
        foreach (hs_q[i]) if (i < NP) begin
            checks++;
            if (hs_q[i] !== {i == NP - 1, 5'(i), model[i]}) begin
                errors++; $display("FAIL stall_pix%0d: got %h expected %h", i, hs_q[i], {i == NP - 1, 5'(i), model[i]});
            end
        end
        for (int j = 0; j + 1 < log_q.size(); j++) begin
            if (log_q[j].v && !log_q[j].r) begin
                stalls++;
                if (!log_q[j + 1].v || log_q[j + 1].idx !== log_q[j].idx || log_q[j + 1].dat !== log_q[j].dat) bad++;
            end
        end
        checks++;
        if (bad != 0 || stalls < NP) begin
            errors++; $display("FAIL stall_stable: got %0d unstable of %0d stalls expected 0 of >=%0d", bad, stalls, NP);
        end
    endtask

    task automatic test_random_ready();
        bit ok;
        for (int n = 0; n < 8; n++) pix_write($urandom_range(0, NP - 1), 24'($urandom));
        log_q.delete();
        apb_write(A_CTRL, 32'h1);
        run_frame(2, 600, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rand_done: got no irq_done expected one within 600 cycles"); end
        m_done = 1'b1;
        collect_hs();
        checks++;
        if (hs_q.size() != NP) begin errors++; $display("FAIL rand_count: got %0d expected %0d", hs_q.size(), NP); end
        foreach (hs_q[i]) if (i < NP) begin
            checks++;
            if (hs_q[i] !== {i == NP - 1, 5'(i), model[i]}) begin
                errors++; $display("FAIL rand_pix%0d: got %h expected %h", i, hs_q[i], {i == NP - 1, 5'(i), model[i]});
            end
        end
    endtask

    task automatic test_pending();
        bit ok1, ok2; logic [31:0] rd; int nirq = 0, first = -1;
        clear_status();
        apb_write(A_CTRL, 32'h1);
        for (int i = 0; i < 100 && !pix_latch; i++) begin pix_ready = 1'b1; tick(); end
        checks++;
        if (pix_latch !== 1'b1) begin errors++; $display("FAIL pend_reach_latch: got latch=%b expected 1", pix_latch); end
        log_q.delete();
        apb_write(A_CTRL, 32'h1);
        apb_write(A_CTRL, 32'h1);
        apb_read(A_CTRL, rd);
        checks++;
        if (rd !== 32'h3) begin errors++; $display("FAIL pend_status_latch: got %h expected 3", rd); end
        run_frame(0, 100, ok1);
        run_frame(0, 200, ok2);
        checks++;
        if (!(ok1 && ok2)) begin errors++; $display("FAIL pend_frames: got done=%b%b expected 11", ok1, ok2); end
        repeat (100) begin pix_ready = 1'b1; tick(); end
        pix_ready = 1'b0;
        m_done = 1'b1;
        foreach (log_q[j]) begin
            if (log_q[j].irq) begin nirq++; if (first < 0) first = j; end
        end
        checks++;
        if (nirq != 2) begin errors++; $display("FAIL pend_irq_count: got %0d expected 2", nirq); end
        checks++;
        if (first < 0 || log_q[first + 1].v !== 1'b1 || log_q[first].v !== 1'b0) begin
            errors++; $display("FAIL pend_restart: got irq pos %0d expected valid on the next cycle", first);
        end
        collect_hs();
        checks++;
        if (hs_q.size() != NP) begin errors++; $display("FAIL pend_count: got %0d expected %0d", hs_q.size(), NP); end
        foreach (hs_q[i]) if (i < NP) begin
            checks++;
            if (hs_q[i] !== {i == NP - 1, 5'(i), model[i]}) begin
                errors++; $display("FAIL pend_pix%0d: got %h expected %h", i, hs_q[i], {i == NP - 1, 5'(i), model[i]});
            end
        end
        apb_read(A_CTRL, rd);
        checks++;
        if (rd !== 32'h4) begin errors++; $display("FAIL pend_status_end: got %h expected 4", rd); end
    endtask

    task automatic test_err_index();
        bit ok; logic [31:0] rd;
        clear_status();
        pix_write(31, 24'($urandom));
        apb_read(A_CTRL, rd);
        checks++;
        if (rd !== 32'h8) begin errors++; $display("FAIL err_status31: got %h expected 8", rd); end
        clear_status();
        apb_read(A_CTRL, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL err_clear: got %h expected 0", rd); end
        pix_write(NP, 24'($urandom));
        apb_read(A_CTRL, rd);
        checks++;
        if (rd !== 32'h8) begin errors++; $display("FAIL err_status30: got %h expected 8", rd); end
        log_q.delete();
        apb_write(A_CTRL, 32'h3);
        m_err = 1'b0;
        run_frame(0, 200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL err_done: got no irq_done expected one"); end
        m_done = 1'b1;
        collect_hs();
        checks++;
        if (hs_q.size() != NP) begin errors++; $display("FAIL err_count: got %0d expected %0d", hs_q.size(), NP); end
        foreach (hs_q[i]) if (i < NP) begin
            checks++;
            if (hs_q[i] !== {i == NP - 1, 5'(i), model[i]}) begin
                errors++; $display("FAIL err_pix%0d: got %h expected %h", i, hs_q[i], {i == NP - 1, 5'(i), model[i]});
            end
        end
        apb_read(A_CTRL, rd);
        checks++;
        if (rd !== 32'h4) begin errors++; $display("FAIL err_status_end: got %h expected 4", rd); end
    endtask

    task automatic test_mid_frame_write();
        bit ok; logic [23:0] exp_f [NP]; logic [23:0] nv;
        clear_status();
        randomize_model();
        for (int i = 0; i < NP; i++) exp_f[i] = model[i];
        log_q.delete();
        apb_write(A_CTRL, 32'h1);
        repeat (10) begin pix_ready = 1'b1; tick(); end
        pix_ready = 1'b0;
        checks++;
        if (pix_index !== 5'd10) begin errors++; $display("FAIL mid_stop_idx: got %0d expected 10", pix_index); end
        nv = 24'($urandom);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = A_PIX; PWDATA = {3'b0, 5'd10, nv}; PENABLE = 1'b0;
        tick();
        PENABLE = 1'b1; pix_ready = 1'b1;
        @(negedge PCLK);
        checks++;
        if (pix_data !== model[10] || pix_index !== 5'd10) begin
            errors++; $display("FAIL mid_same_entry: got idx=%0d data=%h expected 10/%h", pix_index, pix_data, model[10]);
        end
        tick();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; pix_ready = 1'b0;
        model[10] = nv;
        pix_write(5, 24'($urandom));
        pix_write(20, 24'($urandom));
        exp_f[20] = model[20];
        run_frame(0, 200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL mid_done: got no irq_done expected one"); end
        collect_hs();
        checks++;
        if (hs_q.size() != NP) begin errors++; $display("FAIL mid_count: got %0d expected %0d", hs_q.size(), NP); end
        foreach (hs_q[i]) if (i < NP) begin
            checks++;
            if (hs_q[i] !== {i == NP - 1, 5'(i), exp_f[i]}) begin
                errors++; $display("FAIL mid_cur_pix%0d: got %h expected %h", i, hs_q[i], {i == NP - 1, 5'(i), exp_f[i]});
            end
        end
        log_q.delete();
        apb_write(A_CTRL, 32'h1);
        run_frame(0, 200, ok);
        m_done = 1'b1;
        collect_hs();
        checks++;
        if (!ok || hs_q.size() != NP) begin
            errors++; $display("FAIL mid_next_count: got done=%b count=%0d expected 1/%0d", ok, hs_q.size(), NP);
        end
        foreach (hs_q[i]) if (i < NP) begin
            checks++;
            if (hs_q[i] !== {i == NP - 1, 5'(i), model[i]}) begin
                errors++; $display("FAIL mid_next_pix%0d: got %h expected %h", i, hs_q[i], {i == NP - 1, 5'(i), model[i]});
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit ok; logic [31:0] rd; int nv = 0, ni = 0;
        randomize_model();
        apb_write(A_CTRL, 32'h1);
        for (int i = 0; i < 60 && !(pix_valid && pix_index == 5'd12); i++) begin pix_ready = 1'b1; tick(); end
        checks++;
        if (!(pix_valid && pix_index == 5'd12)) begin
            errors++; $display("FAIL rst_reach12: got valid=%b idx=%0d expected 1/12", pix_valid, pix_index);
        end
        #2 PRESERN = 1'b0;
        #1;
        checks++;
        if (pix_valid !== 1'b0 || busy !== 1'b0 || pix_index !== 5'd0) begin
            errors++; $display("FAIL rst_async: got valid=%b busy=%b idx=%0d expected 0/0/0", pix_valid, busy, pix_index);
        end
        log_q.delete();
        repeat (3) tick();
        PRESERN = 1'b1;
        for (int i = 0; i < NP; i++) model[i] = '0;
        m_err = 1'b0; m_done = 1'b0;
        repeat (100) begin pix_ready = 1'b1; tick(); end
        pix_ready = 1'b0;
        foreach (log_q[j]) begin nv += int'(log_q[j].v); ni += int'(log_q[j].irq); end
        checks++;
        if (nv != 0 || ni != 0) begin
            errors++; $display("FAIL rst_quiet: got valid=%0d irq=%0d cycles expected 0/0", nv, ni);
        end
        apb_read(A_CTRL, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL rst_status: got %h expected 0", rd); end
        log_q.delete();
        apb_write(A_CTRL, 32'h1);
        run_frame(0, 200, ok);
        m_done = 1'b1;
        collect_hs();
        checks++;
        if (!ok || hs_q.size() != NP) begin
            errors++; $display("FAIL rst_frame: got done=%b count=%0d expected 1/%0d", ok, hs_q.size(), NP);
        end
        foreach (hs_q[i]) if (i < NP) begin
            checks++;
            if (hs_q[i] !== {i == NP - 1, 5'(i), model[i]}) begin
                errors++; $display("FAIL rst_pix%0d: got %h expected %h", i, hs_q[i], {i == NP - 1, 5'(i), model[i]});
            end
        end
    endtask

`ifdef NEO_AUTO_REFRESH_EN
    task automatic test_auto_refresh();
        bit ok; int gaps = 0, bad = 0;
        apb_write(A_CTRL, 32'h1);
        run_frame(0, 200, ok);
        log_q.delete();
        repeat (2 * (RC + NP + LC) + 50) begin pix_ready = 1'b1; tick(); end
        pix_ready = 1'b0;
        foreach (log_q[j]) if (log_q[j].irq) begin
            for (int q = j; q < log_q.size(); q++) if (log_q[q].v) begin
                gaps++;
                if (q - j != RC) bad++;
                break;
            end
        end
        checks++;
        if (!ok || gaps < 2 || bad != 0) begin
            errors++; $display("FAIL refresh_period: got %0d gaps %0d wrong expected >=2 gaps of %0d", gaps, bad, RC);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_stall();
        test_random_ready();
        test_pending();
        test_err_index();
        test_mid_frame_write();
        test_reset_midframe();
`ifdef NEO_AUTO_REFRESH_EN
        test_auto_refresh();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
